// File: rtl/pwm_audio_out.sv
// pwm_audio_out: syncs the divided sample clock, pops one FIFO sample per tick edge and plays it as glitch-free PWM.
// Optional AUDIO_MIDSCALE_EN: while starved, the pending duty falls back to midscale instead of holding the last sample.
module pwm_audio_out #(
    parameter int DATA_W = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          tick_i,
    input  logic [DATA_W-1:0]             din_i,
    input  logic                          din_valid_i,
    output logic                          din_ready_o,
    output logic                          pwm_o,
    output logic                          underrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [1:0]                    state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, STARVED = 2'd2} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic prev_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] level;
    logic [DATA_W-1:0] cnt, duty_pending, duty_active;
    logic stb, empty, full, push, pop;

    always_comb begin
        stb = sync_q[SYNC_STAGES-1] & ~prev_q;
        empty = level == '0;
        full = level == FULL_LVL;
        push = din_valid_i && !full;
        pop = stb && !empty;
    end

    assign din_ready_o = !full;
    assign fifo_level_o = level;
    assign state_o = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= din_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Emptiness is judged before any same-cycle push, so a strobe racing a push still starves.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            underrun_o <= 1'b0;
            duty_pending <= '0;
        end else begin
            underrun_o <= stb && empty && state != IDLE;
            if (pop) begin
                duty_pending <= mem[rd_ptr];
                state <= PLAY;
            end else if (stb && state != IDLE) begin
                state <= STARVED;
`ifdef AUDIO_MIDSCALE_EN
                duty_pending <= MIDSCALE;
`else
                duty_pending <= duty_pending;
`endif
            end
        end
    end

    // New duty only takes effect at the period boundary so no period is ever split.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
            duty_active <= '0;
            pwm_o <= 1'b0;
        end else begin
            cnt <= cnt + DATA_W'(1);
            if (cnt == '1) duty_active <= duty_pending;
            pwm_o <= state != IDLE && cnt < duty_active;
        end
    end
endmodule
